tristate_bus: RTL and testbench

//  Parametrised bidirectional pad driver with a direction state machine. It enforces
//  hi-Z turnaround cycles on every change of direction, so the pad is never driven

---
 rtl/tristate_pkg.sv | 29 ++
 rtl/tristate_pad_cell.sv | 24 ++
 rtl/tristate_bus.sv | 191 +++++++++++++++++++
 tb/tb_tristate_bus.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tristate_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tristate_pkg
//  Purpose  : Shared types and helpers for the tristate_bus pad driver.
//  Revision : 1.0 - initial release
// ============================================================================
package tristate_pkg;

    // Direction state machine encoding
    typedef enum logic [1:0] {
        HIZ   = 2'd0,
        TURN  = 2'd1,
        DRIVE = 2'd2,
        RECV  = 2'd3
    } tristate_state_e;

    // Width of the turnaround counter; never narrower than one bit so that
    // TURNAROUND=0 still yields a legal vector.
    function automatic int turn_cnt_w(input int turnaround);
        int w;
        w = $clog2(turnaround + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : tristate_pkg
`default_nettype wire

// File: rtl/tristate_pad_cell.sv
`default_nettype none
// ============================================================================
//  Module   : tristate_pad_cell
//  Purpose  : WIDTH-wide bidirectional pad cell. The only tristate driver in
//             the design; q always reflects the resolved pad value.
//  Revision : 1.0 - initial release
// ============================================================================
module tristate_pad_cell #(
    parameter int WIDTH = 8
) (
    input  logic             oe,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    inout  wire  [WIDTH-1:0] pad
);

    // Drive the pad only while the output enable is asserted
    assign pad = oe ? d : {WIDTH{1'bz}};

    // Receive path sees whatever is on the pad, own drive included
    assign q = pad;

endmodule : tristate_pad_cell
`default_nettype wire

// File: rtl/tristate_bus.sv
`default_nettype none
// ============================================================================
//  Module   : tristate_bus
//  Purpose  : Bidirectional pad driver with a direction state machine that
//             inserts TURNAROUND hi-Z cycles on every direction change,
//             a valid/ready transmit interface and a registered receive word.
//  Options  : TRISTATE_KEEPER_EN - in RECV, X/Z pad bits keep the previous
//             rx_data bit and are flagged on rx_z_mask.
//  Revision : 1.0 - initial release
// ============================================================================
module tristate_bus
    import tristate_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TURNAROUND = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    inout  wire  [WIDTH-1:0] pad,
`ifdef TRISTATE_KEEPER_EN
    output logic [WIDTH-1:0] rx_z_mask,
`endif
    output logic             z_state
);

    localparam int                 c_CNT_W   = turn_cnt_w(TURNAROUND);
    localparam logic [c_CNT_W-1:0] c_CNT_LD  = c_CNT_W'(TURNAROUND);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    tristate_state_e    r_state;
    logic               r_oe;
    logic               r_z_state;
    logic               r_tx_ready;
    logic               r_rx_valid;
    logic [WIDTH-1:0]   r_rx_data;
    logic [WIDTH-1:0]   r_out_reg;
    logic [c_CNT_W-1:0] r_turn_cnt;
    logic               r_target;
    logic [WIDTH-1:0]   w_pad_in;
    logic [WIDTH-1:0]   w_rx_next;

    tristate_pad_cell #(
        .WIDTH (WIDTH)
    ) u_pad_cell (
        .oe  (r_oe),
        .d   (r_out_reg),
        .q   (w_pad_in),
        .pad (pad)
    );

`ifdef TRISTATE_KEEPER_EN
    logic [WIDTH-1:0] w_pad_unk;
    logic [WIDTH-1:0] r_rx_z_mask;

    // Flag every pad bit that does not resolve to a clean 0 or 1
    for (genvar i = 0; i < WIDTH; i++) begin : g_keeper
        assign w_pad_unk[i] = $isunknown(w_pad_in[i]);
    end

    assign w_rx_next = (w_pad_in & ~w_pad_unk) | (r_rx_data & w_pad_unk);
    assign rx_z_mask = r_rx_z_mask;

    // Unknown-bit mask follows the receive capture and is cleared elsewhere
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_z_mask <= '0;
        end else if (en && (r_state == RECV) && !dir) begin
            r_rx_z_mask <= w_pad_unk;
        end else begin
            r_rx_z_mask <= '0;
        end
    end
`else
    assign w_rx_next = w_pad_in;
`endif

    // Direction FSM with registered oe/z_state/tx_ready/rx_valid and data paths
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HIZ;
            r_oe       <= 1'b0;
            r_z_state  <= 1'b1;
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_out_reg  <= '0;
            r_turn_cnt <= '0;
            r_target   <= 1'b0;
        end else begin
            // A word offered while ready is high is taken regardless of
            // what the FSM does on the same edge
            if (tx_valid && r_tx_ready) begin
                r_out_reg <= tx_data;
            end
            r_rx_valid <= 1'b0;

            if (!en) begin
                // Release needs no turnaround: stop driving on this edge
                r_state    <= HIZ;
                r_oe       <= 1'b0;
                r_z_state  <= 1'b1;
                r_tx_ready <= 1'b0;
            end else begin
                case (r_state)
                    HIZ: begin
                        if (TURNAROUND == 0) begin
                            r_state    <= dir ? DRIVE : RECV;
                            r_oe       <= dir;
                            r_z_state  <= ~dir;
                            r_tx_ready <= dir;
                        end else begin
                            r_state    <= TURN;
                            r_target   <= dir;
                            r_turn_cnt <= c_CNT_LD;
                        end
                    end

                    TURN: begin
                        if (dir != r_target) begin
                            // Direction changed again: restart the gap
                            r_target   <= dir;
                            r_turn_cnt <= c_CNT_LD;
                        end else if (r_turn_cnt <= c_CNT_ONE) begin
                            r_turn_cnt <= '0;
                            r_state    <= r_target ? DRIVE : RECV;
                            r_oe       <= r_target;
                            r_z_state  <= ~r_target;
                            r_tx_ready <= r_target;
                        end else begin
                            r_turn_cnt <= r_turn_cnt - c_CNT_ONE;
                        end
                    end

                    DRIVE: begin
                        if (!dir) begin
                            r_oe       <= 1'b0;
                            r_z_state  <= 1'b1;
                            r_tx_ready <= 1'b0;
                            if (TURNAROUND == 0) begin
                                r_state <= RECV;
                            end else begin
                                r_state    <= TURN;
                                r_target   <= 1'b0;
                                r_turn_cnt <= c_CNT_LD;
                            end
                        end
                    end

                    RECV: begin
                        if (dir) begin
                            if (TURNAROUND == 0) begin
                                r_state    <= DRIVE;
                                r_oe       <= 1'b1;
                                r_z_state  <= 1'b0;
                                r_tx_ready <= 1'b1;
                            end else begin
                                r_state    <= TURN;
                                r_target   <= 1'b1;
                                r_turn_cnt <= c_CNT_LD;
                            end
                        end else begin
                            // Capture only while staying in RECV so rx_valid
                            // is never seen high outside RECV
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                        end
                    end

                    default: begin
                        r_state <= HIZ;
                        r_oe    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_ready = r_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign z_state  = r_z_state;

endmodule : tristate_bus
`default_nettype wire

// File: tb/tb_tristate_bus.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tristate_bus
//  Purpose  : Directed self-checking bench for tristate_bus; one instance
//             with TURNAROUND=2 and one with TURNAROUND=0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tristate_bus;

    logic       clk;
    logic       rst;
    int         n_vec;
    int         n_err;

    // TURNAROUND=2 instance
    logic       en, dir, tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, rx_valid, z_state;
    logic [7:0] rx_data;
    wire  [7:0] pad;
    logic       tb_pad_oe;
    logic [7:0] tb_pad_drv;

    // TURNAROUND=0 instance
    logic       en0, dir0, tx_valid0;
    logic [7:0] tx_data0;
    logic       tx_ready0, rx_valid0, z_state0;
    logic [7:0] rx_data0;
    wire  [7:0] pad0;
    logic       tb_pad0_oe;
    logic [7:0] tb_pad0_drv;

`ifdef TRISTATE_KEEPER_EN
    logic [7:0] rx_z_mask;
    logic [7:0] rx_z_mask0;
`endif

    assign pad  = tb_pad_oe  ? tb_pad_drv  : 8'hzz;
    assign pad0 = tb_pad0_oe ? tb_pad0_drv : 8'hzz;

    tristate_bus #(.WIDTH(8), .TURNAROUND(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dir       (dir),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .pad       (pad),
`ifdef TRISTATE_KEEPER_EN
        .rx_z_mask (rx_z_mask),
`endif
        .z_state   (z_state)
    );

    tristate_bus #(.WIDTH(8), .TURNAROUND(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .en        (en0),
        .dir       (dir0),
        .tx_data   (tx_data0),
        .tx_valid  (tx_valid0),
        .tx_ready  (tx_ready0),
        .rx_data   (rx_data0),
        .rx_valid  (rx_valid0),
        .pad       (pad0),
`ifdef TRISTATE_KEEPER_EN
        .rx_z_mask (rx_z_mask0),
`endif
        .z_state   (z_state0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        en = 1'b0; dir = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        en0 = 1'b0; dir0 = 1'b0; tx_valid0 = 1'b0; tx_data0 = 8'h00;
        tb_pad_oe = 1'b0; tb_pad_drv = 8'h00;
        tb_pad0_oe = 1'b0; tb_pad0_drv = 8'h00;

        // 1. reset
        tick(); tick();
        rst = 1'b0;
        chk("rst_z_state", z_state, 1);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst0_z_state", z_state0, 1);

        // 2. HIZ -> TURN (2 cycles) -> DRIVE, accept A5
        en = 1'b1; dir = 1'b1; tx_data = 8'hA5; tx_valid = 1'b1;
        tick();
        chk("turn1_z", z_state, 1);
        chk("turn1_rdy", tx_ready, 0);
        tick();
        chk("turn2_z", z_state, 1);
        chk("turn2_rdy", tx_ready, 0);
        tick();
        chk("drive_rdy", tx_ready, 1);
        chk("drive_z", z_state, 0);
        chk("drive_pad_old", pad, 8'h00);
        tick();
        chk("drive_pad_a5", pad, 8'hA5);
        tx_valid = 1'b0;

        // 3. DRIVE -> TURN -> RECV, sample bench-driven pad
        dir = 1'b0;
        tick();
        chk("rel_z", z_state, 1);
        chk("rel_rdy", tx_ready, 0);
        tb_pad_drv = 8'h3C; tb_pad_oe = 1'b1;
        tick();
        tick();
        chk("recv_entry_vld", rx_valid, 0);
        tick();
        chk("recv_data_3c", rx_data, 8'h3C);
        chk("recv_vld", rx_valid, 1);
        tb_pad_drv = 8'h5A;
        tick();
        chk("recv_data_5a", rx_data, 8'h5A);

        // 4. dir toggles during TURN restart the turnaround
        dir = 1'b1;
        tick();
        chk("leave_recv_vld", rx_valid, 0);
        chk("leave_recv_hold", rx_data, 8'h5A);
        tb_pad_oe = 1'b0;
        dir = 1'b0;
        tick();
        chk("tog0_z", z_state, 1);
        dir = 1'b1;
        tick();
        chk("tog1_z", z_state, 1);
        tx_data = 8'h11; tx_valid = 1'b1;
        tick();
        chk("tog_wait_z", z_state, 1);
        chk("tog_wait_rdy", tx_ready, 0);
        tick();
        chk("tog_drive_z", z_state, 0);
        chk("tog_drive_pad", pad, 8'hA5);
        tx_valid = 1'b0;
        tick();
        chk("ignored_tx_pad", pad, 8'hA5);

        // 5. en=0 releases in one edge; rst mid-TURN
        en = 1'b0;
        tick();
        chk("en0_z", z_state, 1);
        chk("en0_rdy", tx_ready, 0);
        en = 1'b1; dir = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        chk("rst_mid_z", z_state, 1);
        chk("rst_mid_rdy", tx_ready, 0);
        chk("rst_mid_vld", rx_valid, 0);
        chk("rst_mid_data", rx_data, 8'h00);
        en = 1'b1; dir = 1'b1;
        tick(); tick(); tick();
        chk("rst_out_reg_z", z_state, 0);
        chk("rst_out_reg_pad", pad, 8'h00);
        en = 1'b0;

        // 6. TURNAROUND=0: direct switches
        en0 = 1'b1; dir0 = 1'b1; tx_data0 = 8'hC3; tx_valid0 = 1'b1;
        tick();
        chk("ta0_drive_z", z_state0, 0);
        chk("ta0_drive_rdy", tx_ready0, 1);
        tick();
        chk("ta0_pad_c3", pad0, 8'hC3);
        tx_valid0 = 1'b0; dir0 = 1'b0;
        tick();
        chk("ta0_recv_z", z_state0, 1);
        chk("ta0_recv_rdy", tx_ready0, 0);
        tb_pad0_drv = 8'h96; tb_pad0_oe = 1'b1;
        tick();
        chk("ta0_rx_data", rx_data0, 8'h96);
        chk("ta0_rx_vld", rx_valid0, 1);
`ifdef TRISTATE_KEEPER_EN
        tb_pad0_oe = 1'b0;
        tick();
        chk("keep_rx_data", rx_data0, 8'h96);
        chk("keep_mask", rx_z_mask0, 8'hFF);
`endif
        tb_pad0_oe = 1'b0; dir0 = 1'b1;
        tick();
        chk("ta0_back_z", z_state0, 0);
        chk("ta0_back_vld", rx_valid0, 0);
        chk("ta0_back_pad", pad0, 8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_tristate_bus
`default_nettype wire
